// File: rtl/tx_serializer.sv
// Two-source message serializer: START word, LSB-first header, payload, optional parity.
// Define TX_PARITY_EN to append a parity cycle carrying the XOR of all payload words.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 2
`endif

module tx_serializer #(
   parameter int IO_BITS        = 2,
   parameter int PAYLOAD_CYCLES = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              pf_command_valid,
   input  logic [`TX_CMD_BITS-1:0]           pf_command,
   output logic                              pf_command_started,
   input  logic [IO_BITS-1:0]                pf_data,
   input  logic                              ex_command_valid,
   input  logic [`TX_CMD_BITS-1:0]           ex_command,
   output logic                              ex_command_started,
   input  logic [IO_BITS-1:0]                ex_data,
   input  logic                              tx_block,
   output logic                              tx_active,
   output logic                              tx_owner_pf,
   output logic                              tx_data_next,
   output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
   output logic                              tx_done,
   output logic [IO_BITS-1:0]                tx_pins
);

   localparam int CMD_W = `TX_CMD_BITS;
   localparam int H     = CMD_W / IO_BITS;
   localparam int CW    = $clog2(PAYLOAD_CYCLES) + 1;
   localparam int HW    = (H > 1) ? $clog2(H) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_HEADER, S_PAYLOAD, S_PARITY
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic [CMD_W-1:0]    hdr_q, hdr_d;
   logic [HW-1:0]       hcnt_q, hcnt_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IO_BITS-1:0]  pins_q, pins_d;
   logic [IO_BITS-1:0]  word;
   logic                pf_start, ex_start;
   logic                last_pay;
`ifdef TX_PARITY_EN
   logic [IO_BITS-1:0]  par_q, par_d;
`endif

   assign word     = owner_q ? pf_data : ex_data;
   assign last_pay = (cnt_q == CW'(PAYLOAD_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      hdr_d    = hdr_q;
      hcnt_d   = hcnt_q;
      cnt_d    = cnt_q;
      pins_d   = '0;
      pf_start = 1'b0;
      ex_start = 1'b0;
`ifdef TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            // ex has priority; the header is latched now so the source may change it afterwards
            if (!tx_block && (ex_command_valid || pf_command_valid)) begin
               state_d  = S_START;
               owner_d  = !ex_command_valid;
               hdr_d    = ex_command_valid ? ex_command : pf_command;
               ex_start = ex_command_valid;
               pf_start = !ex_command_valid;
            end
         end
         S_START: begin
            pins_d  = IO_BITS'(1);
            hcnt_d  = '0;
            cnt_d   = '0;
            state_d = S_HEADER;
`ifdef TX_PARITY_EN
            par_d   = '0;
`endif
         end
         S_HEADER: begin
            pins_d = hdr_q[IO_BITS-1:0];
            hdr_d  = hdr_q >> IO_BITS;
            if (hcnt_q == HW'(H - 1)) state_d = S_PAYLOAD;
            else                      hcnt_d  = hcnt_q + 1'b1;
         end
         S_PAYLOAD: begin
            pins_d = word;
`ifdef TX_PARITY_EN
            par_d  = par_q ^ word;
`endif
            if (last_pay) begin
               cnt_d = '0;
`ifdef TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_IDLE;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef TX_PARITY_EN
         S_PARITY: begin
            pins_d  = par_q;
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         hdr_q   <= '0;
         hcnt_q  <= '0;
         cnt_q   <= '0;
         pins_q  <= '0;
`ifdef TX_PARITY_EN
         par_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hdr_q   <= hdr_d;
         hcnt_q  <= hcnt_d;
         cnt_q   <= cnt_d;
         pins_q  <= pins_d;
`ifdef TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign pf_command_started = pf_start & ~reset;
   assign ex_command_started = ex_start & ~reset;
   assign tx_active          = (state_q != S_IDLE);
   assign tx_owner_pf        = owner_q & tx_active;
   assign tx_data_next       = (state_q == S_PAYLOAD);
   assign tx_pins            = pins_q;

   always_comb begin
      tx_counter = '0;
      if (state_q == S_PAYLOAD)     tx_counter = cnt_q;
      else if (state_q == S_PARITY) tx_counter = CW'(PAYLOAD_CYCLES);
   end

`ifdef TX_PARITY_EN
   assign tx_done = (state_q == S_PARITY);
`else
   assign tx_done = (state_q == S_PAYLOAD) && last_pay;
`endif

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer (IO_BITS=2, PAYLOAD_CYCLES=8, 2-bit header).
`timescale 1ns/1ps
module tb_tx_serializer;
   logic       clk = 1'b0;
   logic       reset;
   logic       pf_command_valid, ex_command_valid, tx_block;
   logic [1:0] pf_command, ex_command, pf_data, ex_data;
   logic       pf_command_started, ex_command_started;
   logic       tx_active, tx_owner_pf, tx_data_next, tx_done;
   logic [3:0] tx_counter;
   logic [1:0] tx_pins;

   int checks = 0;
   int errors = 0;

`ifdef TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   tx_serializer #(.IO_BITS(2), .PAYLOAD_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .pf_command_valid(pf_command_valid), .pf_command(pf_command),
      .pf_command_started(pf_command_started), .pf_data(pf_data),
      .ex_command_valid(ex_command_valid), .ex_command(ex_command),
      .ex_command_started(ex_command_started), .ex_data(ex_data),
      .tx_block(tx_block), .tx_active(tx_active), .tx_owner_pf(tx_owner_pf),
      .tx_data_next(tx_data_next), .tx_counter(tx_counter),
      .tx_done(tx_done), .tx_pins(tx_pins)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs from the cycle after acceptance through the first idle cycle after tx_done.
   task automatic run_msg(input string nm, input bit pf, input logic [1:0] hdr,
                          input logic [15:0] pat, input bit hold_pf);
      logic [1:0] w, par, ep;
      int ea, ec, ed, en;
      par = 2'b00;
      for (int i = 0; i < 8; i++) par ^= pat[2*i +: 2];
      for (int k = 0; k <= 10 + PAR; k++) begin
         tick();
         ex_command_valid = 1'b0;
         if (!hold_pf) pf_command_valid = 1'b0;
         if (k >= 2 && k <= 9) begin
            w = pat[2*(k-2) +: 2];
            pf_data = pf ? w : ~w;
            ex_data = pf ? ~w : w;
         end else begin
            pf_data = 2'b00;
            ex_data = 2'b00;
         end
         @(negedge clk);
         if (k == 0)                  ep = 2'b00;
         else if (k == 1)             ep = 2'b01;
         else if (k == 2)             ep = hdr;
         else if (k <= 10)            ep = pat[2*(k-3) +: 2];
         else                         ep = par;
         ea = (k <= 9 + PAR) ? 1 : 0;
         ed = (k == 9 + PAR) ? 1 : 0;
         en = (k >= 2 && k <= 9) ? 1 : 0;
         ec = en ? k - 2 : ((PAR == 1 && k == 10) ? 8 : 0);
         chk($sformatf("%s pins k%0d", nm, k), tx_pins, ep);
         chk($sformatf("%s active k%0d", nm, k), tx_active, ea);
         chk($sformatf("%s done k%0d", nm, k), tx_done, ed);
         chk($sformatf("%s next k%0d", nm, k), tx_data_next, en);
         chk($sformatf("%s cnt k%0d", nm, k), tx_counter, ec);
         chk($sformatf("%s owner k%0d", nm, k), tx_owner_pf, (pf && ea) ? 1 : 0);
         if (k <= 9 + PAR) begin
            chk($sformatf("%s pf_st k%0d", nm, k), pf_command_started, 0);
            chk($sformatf("%s ex_st k%0d", nm, k), ex_command_started, 0);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      pf_command_valid = 1'b0; ex_command_valid = 1'b0; tx_block = 1'b0;
      pf_command = 2'b00; ex_command = 2'b00; pf_data = 2'b00; ex_data = 2'b00;
      tick(); tick();
      @(negedge clk);
      chk("rst active", tx_active, 0);
      chk("rst pins", tx_pins, 0);
      chk("rst cnt", tx_counter, 0);
      chk("rst done", tx_done, 0);
      tick();
      reset = 1'b0;

      // Basic pf message: header 01, data 0,1,2,3,0,1,2,3
      pf_command_valid = 1'b1; pf_command = 2'b01;
      @(negedge clk);
      chk("t1 pf_st", pf_command_started, 1);
      chk("t1 ex_st", ex_command_started, 0);
      run_msg("t1", 1'b1, 2'b01, 16'hE4E4, 1'b0);
      tick();
      @(negedge clk);
      chk("t1 gap pins", tx_pins, 0);

      // Simultaneous requests: ex wins, pf follows right after tx_done
      tick();
      pf_command_valid = 1'b1; pf_command = 2'b01;
      ex_command_valid = 1'b1; ex_command = 2'b10;
      @(negedge clk);
      chk("t2 ex_st", ex_command_started, 1);
      chk("t2 pf_st", pf_command_started, 0);
      run_msg("t2", 1'b0, 2'b10, 16'h1B6C, 1'b1);
      chk("t2 b2b pf_st", pf_command_started, 1);
      chk("t2 b2b ex_st", ex_command_started, 0);
      run_msg("t2b", 1'b1, 2'b01, 16'h3FC0, 1'b0);

      // tx_block holds off a pending pf request
      tick();
      tx_block = 1'b1; pf_command_valid = 1'b1; pf_command = 2'b11;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t3 blk pf_st %0d", i), pf_command_started, 0);
         chk($sformatf("t3 blk active %0d", i), tx_active, 0);
         tick();
      end
      tx_block = 1'b0;
      @(negedge clk);
      chk("t3 pf_st", pf_command_started, 1);
      run_msg("t3", 1'b1, 2'b11, 16'h9C5A, 1'b0);

      // Reset mid-message at tx_counter=3
      tick();
      ex_command_valid = 1'b1; ex_command = 2'b10;
      @(negedge clk);
      chk("t4 ex_st", ex_command_started, 1);
      for (int k = 0; k <= 5; k++) begin
         tick();
         ex_command_valid = 1'b0;
         ex_data = 2'b11;
         if (k == 5) reset = 1'b1;
         @(negedge clk);
      end
      chk("t4 cnt before", tx_counter, 3);
      chk("t4 done before", tx_done, 0);
      tick();
      pf_command_valid = 1'b1; pf_command = 2'b01;
      @(negedge clk);
      chk("t4 active", tx_active, 0);
      chk("t4 pins", tx_pins, 0);
      chk("t4 cnt", tx_counter, 0);
      chk("t4 done", tx_done, 0);
      chk("t4 pf_st in reset", pf_command_started, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t4 pf_st after", pf_command_started, 1);
      run_msg("t4", 1'b1, 2'b01, 16'h0F0F, 1'b0);

`ifdef TX_PARITY_EN
      tick();
      pf_command_valid = 1'b1; pf_command = 2'b10;
      @(negedge clk);
      chk("t5 pf_st", pf_command_started, 1);
      run_msg("t5", 1'b1, 2'b10, 16'hFFFF, 1'b0);
      tick();
      pf_command_valid = 1'b1; pf_command = 2'b01;
      @(negedge clk);
      chk("t6 pf_st", pf_command_started, 1);
      run_msg("t6", 1'b1, 2'b01, 16'h0001, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter IO_BITS, default 2, meaning pin bus width and bits per transfer cycle.
REQ-002 SHALL have parameter PAYLOAD_CYCLES, default 8, meaning payload cycles per message.
REQ-003 SHALL take header width from `TX_CMD_BITS (common.vh); `TX_CMD_BITS SHALL be a multiple of IO_BITS; H = `TX_CMD_BITS/IO_BITS header cycles.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 pf_command_valid  input  1  prefetcher requests a message.
REQ-008 pf_command  input  `TX_CMD_BITS  prefetcher header.
REQ-009 pf_command_started  output  1  pulse: prefetcher message accepted.
REQ-010 pf_data  input  IO_BITS  prefetcher payload word.
REQ-011 ex_command_valid  input  1  execution unit requests a message.
REQ-012 ex_command  input  `TX_CMD_BITS  execution unit header.
REQ-013 ex_command_started  output  1  pulse: execution message accepted.
REQ-014 ex_data  input  IO_BITS  execution payload word.
REQ-015 tx_block  input  1  inhibits acceptance of new messages.
REQ-016 tx_active  output  1  message in progress.
REQ-017 tx_owner_pf  output  1  current message belongs to prefetcher.
REQ-018 tx_data_next  output  1  payload word consumed this cycle.
REQ-019 tx_counter  output  $clog2(PAYLOAD_CYCLES)+1  payload cycle index.
REQ-020 tx_done  output  1  final cycle of message.
REQ-021 tx_pins  output  IO_BITS  registered serial output.

Function
REQ-022 SHALL implement states IDLE -> START (1 cycle) -> HEADER (H cycles) -> PAYLOAD (PAYLOAD_CYCLES cycles) -> [PARITY (1 cycle)] -> IDLE.
REQ-023 Acceptance SHALL occur only in IDLE with !tx_block and at least one valid; next state START.
REQ-024 On simultaneous valids, ex SHALL win; exactly one started pulse, in the acceptance cycle, combinational.
REQ-025 Winning header SHALL be captured at acceptance; owner recorded in tx_owner_pf, held until return to IDLE.
REQ-026 Word computed per state cycle SHALL appear on tx_pins the following cycle: IDLE 0; START bit0=1, others 0; HEADER header LSB-first, IO_BITS per cycle; PAYLOAD owner's data input sampled that cycle.
REQ-027 tx_data_next SHALL be high exactly in PAYLOAD cycles; tx_counter SHALL be 0..PAYLOAD_CYCLES-1 in PAYLOAD, PAYLOAD_CYCLES in PARITY, 0 otherwise.
REQ-028 tx_active SHALL be high in all non-IDLE states.
REQ-029 tx_done SHALL pulse in final state cycle (last PAYLOAD or PARITY).
REQ-030 Back-to-back: acceptance allowed in first IDLE cycle after tx_done, giving one idle (0) pin cycle between messages.
REQ-031 tx_block SHALL not affect a message already accepted.
REQ-032 Valids deasserting mid-message SHALL be ignored; data inputs are the source's responsibility.

Reset
REQ-033 Reset SHALL force IDLE, counter 0, tx_pins 0 next cycle; all outputs low/0.
REQ-034 Reset mid-message SHALL abort with no tx_done; started outputs SHALL be 0 while reset is high.

Configuration
REQ-035 TX_PARITY_EN defined: PARITY state present, pins carry XOR of all PAYLOAD words; undefined: PAYLOAD last state, no parity logic.

Verification
REQ-036 IO_BITS=2, PAYLOAD_CYCLES=8, `TX_CMD_BITS=2, no parity: pf_command=01, pf_data 0,1,2,3,0,1,2,3 -> pins 01,01,0,1,2,3,0,1,2,3,00; counter 0..7; tx_done at counter 7.
REQ-037 Both valid same cycle -> ex_command_started only, tx_owner_pf=0; pf_command_started in IDLE cycle after tx_done.
REQ-038 tx_block=1 with pf valid 5 cycles -> no start, tx_active 0; tx_block falls -> pf_command_started same cycle.
REQ-039 Reset at tx_counter=3 -> tx_active 0 next cycle, tx_pins 0, no tx_done.
REQ-040 TX_PARITY_EN: data all 11 -> parity 00; data 01 then seven 00 -> parity 01; tx_counter=8 and tx_done in parity cycle.
